// File: rtl/gs_mem_arbiter.sv
// gs_mem_arbiter: GS byte port and loader write port onto 64-bit DDRAM,
// one-line read cache, loader-first arbitration.
//
// Ports
//   clk_sys, reset_n         clock, async active-low reset
//   gs_addr/din/rd/wr        GS byte request (levels held until gs_ready)
//   gs_dout, gs_ready        GS read data, access complete/idle
//   ld_addr/din/wr, ld_busy  loader write strobe, one-entry buffer status
//   size_sel                 GS window: 0=512KB 1=1MB 2/3=2MB
//   ddr_*                    DDRAM command/data port (single-word bursts)
module gs_mem_arbiter #(
  parameter logic [28:0] DDR_BASE      = 29'h0300000,
  parameter int          ROM_SIZE_LOG2 = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [20:0] gs_addr,
  input  logic [7:0]  gs_din,
  input  logic        gs_rd,
  input  logic        gs_wr,
  output logic [7:0]  gs_dout,
  output logic        gs_ready,
  input  logic [20:0] ld_addr,
  input  logic [7:0]  ld_din,
  input  logic        ld_wr,
  output logic        ld_busy,
  input  logic [1:0]  size_sel,
  input  logic        ddr_busy,
  output logic [28:0] ddr_addr,
  output logic [7:0]  ddr_burstcnt,
  output logic        ddr_rd,
  output logic        ddr_we,
  output logic [7:0]  ddr_be,
  output logic [63:0] ddr_din,
  input  logic [63:0] ddr_dout,
  input  logic        ddr_dout_ready
);

  // The ROM region has to be word aligned and fit in the 2MB space.
  if (ROM_SIZE_LOG2 < 3 || ROM_SIZE_LOG2 > 21) begin : g_rom_chk
    $error("gs_mem_arbiter: ROM_SIZE_LOG2 out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    RD_CMD,
    RD_WAIT,
    WR_CMD
  } state_t;

  state_t      state;

  logic        gs_rd_q;
  logic        gs_wr_q;
  logic [1:0]  size_q;

  // GS request captured on the level edge
  logic        req_pend;
  logic        req_wr;
  logic [20:0] req_addr;
  logic [7:0]  req_din;

  // one-entry loader buffer
  logic        ld_pend;
  logic [20:0] ld_addr_q;
  logic [7:0]  ld_din_q;

  // access currently owning the DDRAM port
  logic        cur_ld;
  logic [20:0] cur_addr;
  logic [7:0]  cur_din;

  // one-line read cache
  logic        cache_vld;
  logic [17:0] cache_tag;
  logic [63:0] cache_data;

  logic        rd_edge;
  logic        wr_edge;
  logic        req_ok;
  logic        req_hit;
  logic        cur_hit;
  logic [7:0]  hit_byte;
  logic [7:0]  fill_byte;

  function automatic logic [28:0] word_addr(input logic [20:0] a);
    return DDR_BASE + {11'd0, a[20:3]};
  endfunction

  function automatic logic [7:0] lane(input logic [2:0] a);
    return 8'd1 << a;
  endfunction

  assign rd_edge      = gs_rd & ~gs_rd_q;
  assign wr_edge      = gs_wr & ~gs_wr_q;
  assign ld_busy      = ld_pend;
  assign ddr_burstcnt = 8'd1;

  always_comb begin
    req_ok = 1'b1;
    unique case (1'b1)
      size_sel == 2'd0: req_ok = req_addr[20:19] == 2'b00;
      size_sel == 2'd1: req_ok = ~req_addr[20];
      default:          req_ok = 1'b1;
    endcase
  end

  assign req_hit   = cache_vld && (cache_tag == req_addr[20:3]);
  assign cur_hit   = cache_vld && (cache_tag == cur_addr[20:3]);
  assign hit_byte  = cache_data[{req_addr[2:0], 3'b000} +: 8];
  assign fill_byte = ddr_dout[{cur_addr[2:0], 3'b000} +: 8];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      gs_rd_q    <= 1'b0;
      gs_wr_q    <= 1'b0;
      size_q     <= 2'd0;
      req_pend   <= 1'b0;
      req_wr     <= 1'b0;
      req_addr   <= '0;
      req_din    <= '0;
      ld_pend    <= 1'b0;
      ld_addr_q  <= '0;
      ld_din_q   <= '0;
      cur_ld     <= 1'b0;
      cur_addr   <= '0;
      cur_din    <= '0;
      cache_vld  <= 1'b0;
      cache_tag  <= '0;
      cache_data <= '0;
      gs_ready   <= 1'b1;
      gs_dout    <= 8'hFF;
      ddr_rd     <= 1'b0;
      ddr_we     <= 1'b0;
      ddr_be     <= '0;
      ddr_din    <= '0;
      ddr_addr   <= DDR_BASE;
    end else begin
      gs_rd_q <= gs_rd;
      gs_wr_q <= gs_wr;
      size_q  <= size_sel;

      // A write edge wins over a simultaneous read edge.
      if ((rd_edge || wr_edge) && !req_pend) begin
        req_pend <= 1'b1;
        req_wr   <= wr_edge;
        req_addr <= gs_addr;
        req_din  <= gs_din;
        gs_ready <= 1'b0;
      end

      if (ld_wr && !ld_pend) begin
        ld_pend   <= 1'b1;
        ld_addr_q <= ld_addr;
        ld_din_q  <= ld_din;
      end

      case (state)
        IDLE: begin
          if (ld_pend) begin
            // Loader goes first; any GS request waits in req_pend.
            state     <= WR_CMD;
            cur_ld    <= 1'b1;
            cur_addr  <= ld_addr_q;
            cur_din   <= ld_din_q;
            cache_vld <= 1'b0;
            ddr_we    <= 1'b1;
            ddr_addr  <= word_addr(ld_addr_q);
            ddr_be    <= lane(ld_addr_q[2:0]);
            ddr_din   <= {8{ld_din_q}};
          end else if (req_pend) begin
            cur_ld   <= 1'b0;
            cur_addr <= req_addr;
            cur_din  <= req_din;
            if (!req_ok) begin
              gs_ready <= 1'b1;
              req_pend <= 1'b0;
              if (!req_wr) gs_dout <= 8'hFF;
            end else if (req_wr) begin
              state    <= WR_CMD;
              ddr_we   <= 1'b1;
              ddr_addr <= word_addr(req_addr);
              ddr_be   <= lane(req_addr[2:0]);
              ddr_din  <= {8{req_din}};
            end else if (req_hit) begin
              gs_dout  <= hit_byte;
              gs_ready <= 1'b1;
              req_pend <= 1'b0;
            end else begin
              state    <= RD_CMD;
              ddr_rd   <= 1'b1;
              ddr_addr <= word_addr(req_addr);
            end
          end
        end

        RD_CMD: begin
          if (!ddr_busy) begin
            ddr_rd <= 1'b0;
            state  <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (ddr_dout_ready) begin
            cache_vld  <= 1'b1;
            cache_tag  <= cur_addr[20:3];
            cache_data <= ddr_dout;
            gs_dout    <= fill_byte;
            gs_ready   <= 1'b1;
            req_pend   <= 1'b0;
            state      <= IDLE;
          end
        end

        WR_CMD: begin
          if (!ddr_busy) begin
            ddr_we <= 1'b0;
            ddr_be <= '0;
            state  <= IDLE;
            if (cur_ld) begin
              ld_pend <= 1'b0;
            end else begin
              gs_ready <= 1'b1;
              req_pend <= 1'b0;
              // write-through: keep a cached copy of this line coherent
              if (cur_hit) begin
                cache_data[{cur_addr[2:0], 3'b000} +: 8] <= cur_din;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase

      // A new window size makes the cached line stale; placed last so
      // it overrides a fill landing in the same cycle.
      if (size_sel != size_q) cache_vld <= 1'b0;
    end
  end

endmodule
